// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor with a direct-mapped BTB and a mispredict redirect FSM.
// Fetch looks up if_pc combinationally; EX resolves train the table and may request a redirect.
module branch_predict_ctrl #(
  parameter int IDX_BITS = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count,
  output logic [1:0]      o_dbg_state
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_redirect;
  logic [1:0]            r_ctr    [ENTRIES];
  logic [XLEN-1:0]       r_target [ENTRIES];
  logic [ENTRIES-1:0]    r_valid;
  logic [XLEN-1:0]       r_redirect_pc;
  logic [31:0]           r_br_count;
  logic [31:0]           r_mispred_count;
  logic [IDX_BITS-1:0]   w_if_idx;
  logic [IDX_BITS-1:0]   w_ex_idx;
  logic                  w_accept;
  logic                  w_mispred;
  logic [XLEN-1:0]       w_correct_pc;
  logic                  w_unused;

  assign w_if_idx = if_pc[IDX_BITS+1:2];
  assign w_ex_idx = ex_pc[IDX_BITS+1:2];
  assign w_unused = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0]};

  // Lookup reads only registered state, so a same-cycle update is not visible yet.
  assign pred_taken  = r_valid[w_if_idx] & r_ctr[w_if_idx][1];
  assign pred_target = r_target[w_if_idx];

  // Resolves arriving while a redirect is in flight are wrong-path and dropped.
  assign w_accept     = ex_valid & ex_branch & (r_state == S_IDLE);
  assign w_mispred    = (ex_taken != ex_pred_taken) |
                        (ex_taken & ex_pred_taken & (ex_target != ex_pred_target));
  assign w_correct_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

  always_comb begin
    w_next_state = r_state;
    w_redirect   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_mispred) w_next_state = S_REDIRECT;
      end
      S_REDIRECT: begin
        w_redirect   = 1'b1;
        w_next_state = stall ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        w_redirect = 1'b1;
        if (!stall) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign redirect_valid = w_redirect;
  assign flush_if_id    = w_redirect;
  assign flush_id_ex    = w_redirect;
  assign redirect_pc    = r_redirect_pc;
  assign br_count       = r_br_count;
  assign mispred_count  = r_mispred_count;
  assign o_dbg_state    = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept && w_mispred) r_redirect_pc <= w_correct_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i]    <= 2'b01;
        r_target[i] <= '0;
      end
      r_valid <= '0;
    end else if (w_accept) begin
      if (ex_taken) begin
        if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
        r_target[w_ex_idx] <= ex_target;
        r_valid[w_ex_idx]  <= 1'b1;
      end else if (r_ctr[w_ex_idx] != 2'b00) begin
        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (w_accept) begin
      if (r_br_count != 32'hFFFF_FFFF) r_br_count <= r_br_count + 32'd1;
      if (w_mispred && (r_mispred_count != 32'hFFFF_FFFF))
        r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: table/counter model plus a redirect scoreboard
// (expected redirect pc and pulse length queued at resolve, checked when the DUT redirects).
module tb_branch_predict_ctrl;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic            ex_branch;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic [31:0]     br_count;
  logic [31:0]     mispred_count;
  logic [1:0]      o_dbg_state;

  branch_predict_ctrl #(.IDX_BITS(4), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .br_count(br_count), .mispred_count(mispred_count), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] exp_q[$];
  int              len_q[$];

  logic [1:0]      m_ctr    [16];
  logic            m_valid  [16];
  logic [XLEN-1:0] m_target [16];
  logic [31:0]     m_br;
  logic [31:0]     m_mis;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_ctr[i] = 2'b01; m_valid[i] = 1'b0; m_target[i] = '0;
    end
    m_br = 0; m_mis = 0;
  endfunction

  function automatic logic model_resolve(input logic [31:0] pc, input logic tk,
                                         input logic [31:0] tgt, input logic ptk,
                                         input logic [31:0] ptgt);
    logic       mis;
    logic [3:0] idx;
    idx = pc[5:2];
    mis = (tk != ptk) || (tk && ptk && (tgt != ptgt));
    if (mis) exp_q.push_back(tk ? tgt : pc + 32'd4);
    if (tk) begin
      if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
      m_target[idx] = tgt;
      m_valid[idx]  = 1'b1;
    end else if (m_ctr[idx] != 2'b00) begin
      m_ctr[idx] = m_ctr[idx] - 2'd1;
    end
    m_br++;
    if (mis) m_mis++;
    return mis;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lookup(input string tag, input logic [31:0] pc);
    logic [3:0] idx;
    idx   = pc[5:2];
    if_pc = pc;
    #1;
    check_eq({tag, "_taken"},  pred_taken,  m_valid[idx] & m_ctr[idx][1]);
    check_eq({tag, "_target"}, pred_target, m_target[idx]);
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_br"},  br_count,      m_br);
    check_eq({tag, "_mis"}, mispred_count, m_mis);
  endtask

  // One accepted resolve; if it mispredicts, stall is held for hold_cycles while
  // wrong-path resolves are presented, then the task returns with the FSM idle.
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt, input int hold_cycles);
    logic mis;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    check_lookup("same_cycle", pc);
    mis = model_resolve(pc, tk, tgt, ptk, ptgt);
    if (mis) len_q.push_back(1 + hold_cycles);
    tick();
    ex_valid = 1'b0; ex_branch = 1'b0;
    if (mis) begin
      if (hold_cycles > 0) begin
        stall = 1'b1;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 32'h40; ex_taken = 1'b1;
        ex_target = 32'hDEAD_0000; ex_pred_taken = 1'b0; ex_pred_target = '0;
        for (int i = 0; i < hold_cycles; i++) tick();
        stall = 1'b0;
      end
      tick();
      ex_valid = 1'b0; ex_branch = 1'b0;
    end
  endtask

  // ---------------- redirect monitor / scoreboard ----------------
  logic            mon_prev = 1'b0;
  int              mon_len  = 0;
  logic [XLEN-1:0] mon_pc   = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0;
      mon_len  = 0;
    end else begin
      check_eq("flush_if_id", flush_if_id, redirect_valid);
      check_eq("flush_id_ex", flush_id_ex, redirect_valid);
      if (redirect_valid) begin
        if (!mon_prev) begin
          if (exp_q.size() == 0) check_eq("unexpected_redirect", redirect_valid, 1'b0);
          else begin
            mon_pc = exp_q.pop_front();
            check_eq("redirect_pc", redirect_pc, mon_pc);
          end
          mon_len = 1;
        end else begin
          mon_len++;
          check_eq("redirect_pc_hold", redirect_pc, mon_pc);
        end
      end else if (mon_prev) begin
        if (len_q.size() != 0) check_eq("redirect_len", mon_len, len_q.pop_front());
        else check_eq("redirect_len_unexpected", mon_len, 0);
      end
      mon_prev = redirect_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic            mis;
    logic [31:0]     r_pc, r_tgt, r_ptgt;
    logic            r_tk, r_ptk;
    rst_n = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_branch = 1'b0; ex_pc = '0;
    ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    stall = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_redirect_valid", redirect_valid, 1'b0);
    check_eq("rst_redirect_pc", redirect_pc, 32'h0);
    check_eq("rst_state", o_dbg_state, 2'd0);
    check_counters("rst");
    check_lookup("rst_lookup_100", 32'h100);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Cold branch taken twice: both mispredict, then table predicts taken to 0x200.
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 0);
    check_counters("first_taken");
    check_lookup("after_first_100", 32'h100);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 0);
    check_lookup("after_second_100", 32'h100);
    check_counters("second_taken");

    // Correct prediction: no redirect, only br_count moves.
    resolve(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 0);
    check_counters("correct_pred");

    // Predicted taken, resolves not taken -> fall-through pc.
    resolve(32'h104, 1'b0, 32'h0, 1'b1, 32'h200, 0);
    check_counters("not_taken_mis");

    // Mispredict with 3 stall cycles; wrong-path resolves in the meantime are ignored.
    resolve(32'h180, 1'b1, 32'h280, 1'b0, 32'h0, 3);
    check_counters("stall_hold");
    check_lookup("wrong_path_40", 32'h40);

    // Target mismatch and PC wraparound.
    resolve(32'h208, 1'b1, 32'h300, 1'b1, 32'h200, 0);
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 0);
    check_counters("target_wrap");

    // Random traffic over a few aliasing indices.
    for (int n = 0; n < 24; n++) begin
      r_pc   = 32'h1000 + ($urandom_range(0, 7) << 2);
      r_tk   = 1'($urandom_range(0, 1));
      r_ptk  = 1'($urandom_range(0, 1));
      r_tgt  = 32'h2000 + ($urandom_range(0, 3) << 4);
      r_ptgt = 32'h2000 + ($urandom_range(0, 3) << 4);
      resolve(r_pc, r_tk, r_tgt, r_ptk, r_ptgt, int'($urandom_range(0, 2)));
    end
    check_counters("random");
    for (int i = 0; i < 8; i++) check_lookup("random_lookup", 32'h1000 + 32'(i << 2));

    // Reset asserted while the FSM sits in HOLD.
    ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 32'h600; ex_taken = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b1; ex_pred_target = 32'h700;
    mis = model_resolve(32'h600, 1'b0, 32'h0, 1'b1, 32'h700);
    check_eq("hold_rst_mis_model", mis, 1'b1);
    tick();
    ex_valid = 1'b0; ex_branch = 1'b0; stall = 1'b1;
    tick(); tick();
    check_eq("hold_state", o_dbg_state, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("hold_rst_redirect_valid", redirect_valid, 1'b0);
    check_eq("hold_rst_state", o_dbg_state, 2'd0);
    model_reset();
    check_counters("hold_rst");
    len_q.delete();
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check_eq("post_rst_state", o_dbg_state, 2'd0);
    check_eq("post_rst_redirect_valid", redirect_valid, 1'b0);
    check_lookup("post_rst_lookup_100", 32'h100);

    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("len_q_empty", len_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, meaning log2 of predictor/BTB entry count (16 entries).
REQ-002 SHALL have parameter XLEN, default 32, meaning PC/target width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 if_pc  input  XLEN  fetch-stage PC used for lookup.
REQ-006 pred_taken  output  1  fetch prediction: branch predicted taken.
REQ-007 pred_target  output  XLEN  predicted target for if_pc.
REQ-008 ex_valid  input  1  EX-stage instruction valid.
REQ-009 ex_branch  input  1  EX-stage instruction is a conditional branch.
REQ-010 ex_pc  input  XLEN  PC of the EX-stage instruction.
REQ-011 ex_taken  input  1  resolved outcome from branch_control (branch_taken).
REQ-012 ex_target  input  XLEN  resolved branch target.
REQ-013 ex_pred_taken, ex_pred_target  input  1, XLEN  prediction carried down the pipeline with the instruction.
REQ-014 stall  input  1  pipeline stall; fetch cannot accept a redirect while high.
REQ-015 redirect_valid  output  1  PC redirect request to fetch.
REQ-016 redirect_pc  output  XLEN  corrected PC.
REQ-017 flush_if_id, flush_id_ex  output  1 each  squash the named pipeline registers.
REQ-018 br_count, mispred_count  output  32 each  statistics counters.

Function
REQ-019 Index SHALL be idx = pc[IDX_BITS+1:2]; table per entry: 2-bit counter ctr, 1-bit valid, XLEN-bit target.
REQ-020 pred_taken SHALL equal valid[idx(if_pc)] AND ctr[idx(if_pc)][1]; pred_target = target[idx(if_pc)]; combinational from registered table.
REQ-021 A resolve is accepted when ex_valid AND ex_branch AND FSM in IDLE; resolves in REDIRECT or HOLD SHALL be ignored entirely (wrong-path).
REQ-022 Accepted resolve SHALL update ctr[idx(ex_pc)]: taken -> increment saturating at 3; not taken -> decrement saturating at 0.
REQ-023 Accepted taken resolve SHALL write target[idx(ex_pc)] = ex_target and set valid; not-taken resolve SHALL leave target/valid unchanged.
REQ-024 Same-cycle lookup and update of same index: lookup SHALL return pre-update value.
REQ-025 mispredict = (ex_taken != ex_pred_taken) OR (ex_taken AND ex_pred_taken AND ex_target != ex_pred_target).
REQ-026 Correct pc: ex_taken ? ex_target : ex_pc + 4 (XLEN-bit, wrap modulo 2^XLEN).
REQ-027 FSM states IDLE, REDIRECT, HOLD. IDLE + accepted mispredict -> REDIRECT, latching correct pc into redirect_pc.
REQ-028 REDIRECT: redirect_valid, flush_if_id, flush_id_ex = 1; stall low -> IDLE next cycle; stall high -> HOLD.
REQ-029 HOLD: same outputs as REDIRECT, redirect_pc stable; exit to IDLE on first cycle stall is low (that cycle still drives outputs).
REQ-030 Latency: mispredict resolved in cycle N -> redirect_valid high in cycle N+1; minimum pulse one cycle.
REQ-031 Outside REDIRECT/HOLD, redirect_valid and flush outputs SHALL be 0; redirect_pc holds last latched value.
REQ-032 br_count SHALL increment per accepted resolve; mispred_count per accepted mispredict; both saturate at 32'hFFFF_FFFF.

Reset
REQ-033 rst_n low SHALL immediately force: FSM IDLE, redirect_valid/flush outputs 0, redirect_pc 0, all ctr = 2'b01, all valid 0, all target 0, both counters 0.
REQ-034 Reset asserted mid-REDIRECT/HOLD SHALL abort the redirect; no redirect after rst_n deasserts.

Verification
REQ-035 After reset, if_pc=0x100 -> pred_taken=0, pred_target=0; ctr[0]=01.
REQ-036 Two accepted taken resolves at ex_pc=0x100, ex_target=0x200, ex_pred_taken=0 -> first: redirect_pc=0x200 next cycle, mispred_count=1; lookup 0x100 then pred_taken=1, pred_target=0x200.
REQ-037 Predicted taken 0x200, resolves not taken at ex_pc=0x104 -> redirect_pc=0x108, flush_if_id=flush_id_ex=1 for one cycle.
REQ-038 Mispredict with stall high 3 cycles after resolve -> redirect_valid high 4 cycles, redirect_pc constant; ex_valid resolves during those cycles leave br_count unchanged.
REQ-039 Taken, pred_taken=1, ex_target=0x300, ex_pred_target=0x200 -> mispredict, redirect_pc=0x300; ex_pc=0xFFFF_FFFC not taken mispredict -> redirect_pc=0x0.
REQ-040 rst_n asserted during HOLD -> redirect_valid 0 asynchronously, counters 0, FSM IDLE after release.
